// File: rtl/zynq_axil_pkg.sv
// Shared AXI4-Lite definitions for the PS-to-PL CSR responder slice.
package zynq_axil_pkg;

  localparam int unsigned axil_addr_max_lp = 32;
  localparam int unsigned axil_data_lp     = 32;

  typedef enum logic [1:0] {
    e_axil_okay   = 2'b00,
    e_axil_slverr = 2'b10
  } axil_resp_e;

  // Joined write request; the address is zero-extended to the widest supported bus.
  typedef struct packed {
    logic [axil_addr_max_lp-1:0] addr;
    logic [axil_data_lp-1:0]     data;
    logic [axil_data_lp/8-1:0]   strb;
  } axil_wr_hold_s;

endpackage

// File: rtl/zynq_axil_wr_join.sv
// AW/W hold registers: each channel fills independently, and one commit drains both.
module zynq_axil_wr_join
  import zynq_axil_pkg::*;
#(
  parameter int unsigned addr_width_p = 10
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [addr_width_p-1:0] awaddr_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [31:0]             wdata_i,
  input  logic [3:0]              wstrb_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  input  logic                    b_stall_i,
  output logic                    commit_o,
  output axil_wr_hold_s           hold_o
);

  logic          aw_full_q, aw_full_d;
  logic          w_full_q, w_full_d;
  axil_wr_hold_s hold_q, hold_d;

  always_comb begin
    awready_o = ~aw_full_q & ~reset_i;
    wready_o  = ~w_full_q & ~reset_i;
    commit_o  = aw_full_q & w_full_q & ~b_stall_i;

    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    hold_d    = hold_q;

    if (commit_o) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end
    // A full hold never accepts, so a fill cannot collide with the commit that drains it.
    if (awvalid_i & awready_o) begin
      aw_full_d   = 1'b1;
      hold_d.addr = 32'(awaddr_i);
    end
    if (wvalid_i & wready_o) begin
      w_full_d    = 1'b1;
      hold_d.data = wdata_i;
      hold_d.strb = wstrb_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      hold_q    <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      hold_q    <= hold_d;
    end
  end

  assign hold_o = hold_q;

endmodule

// File: rtl/zynq_axil_csr_responder.sv
// AXI4-Lite subordinate exposing R/W CSRs and read-only status words to PL logic.
module zynq_axil_csr_responder
  import zynq_axil_pkg::*;
#(
  parameter int unsigned addr_width_p = 10,
  parameter int unsigned data_width_p = 32,
  parameter int unsigned num_csr_p    = 4,
  parameter int unsigned num_ro_p     = 2
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [addr_width_p-1:0]       awaddr_i,
  input  logic [2:0]                    awprot_i,
  input  logic                          awvalid_i,
  output logic                          awready_o,
  input  logic [data_width_p-1:0]       wdata_i,
  input  logic [3:0]                    wstrb_i,
  input  logic                          wvalid_i,
  output logic                          wready_o,
  output logic [1:0]                    bresp_o,
  output logic                          bvalid_o,
  input  logic                          bready_i,
  input  logic [addr_width_p-1:0]       araddr_i,
  input  logic [2:0]                    arprot_i,
  input  logic                          arvalid_i,
  output logic                          arready_o,
  output logic [data_width_p-1:0]       rdata_o,
  output logic [1:0]                    rresp_o,
  output logic                          rvalid_o,
  input  logic                          rready_i,
  output logic [num_csr_p*32-1:0]       csr_data_o,
  output logic [num_csr_p-1:0]          csr_w_v_o,
  input  logic [num_ro_p*32-1:0]        ro_data_i
);

  logic [num_csr_p-1:0][31:0] csr_q, csr_d;
  logic [num_csr_p-1:0]       csr_w_v_q, csr_w_v_d;
  logic                       bvalid_q, bvalid_d;
  logic [1:0]                 bresp_q, bresp_d;
  logic                       rvalid_q, rvalid_d;
  logic [1:0]                 rresp_q, rresp_d;
  logic [31:0]                rdata_q, rdata_d;

  logic                       commit;
  axil_wr_hold_s              hold;
  logic [29:0]                wr_idx, rd_idx;
  logic [31:0]                ar_addr_ext;
  logic                       unused_bits;

  assign unused_bits = ^{awprot_i, arprot_i, ar_addr_ext[1:0], hold.addr[1:0]};

  zynq_axil_wr_join #(
    .addr_width_p(addr_width_p)
  ) wr_join (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .awaddr_i (awaddr_i),
    .awvalid_i(awvalid_i),
    .awready_o(awready_o),
    .wdata_i  (wdata_i),
    .wstrb_i  (wstrb_i),
    .wvalid_i (wvalid_i),
    .wready_o (wready_o),
    .b_stall_i(bvalid_q & ~bready_i),
    .commit_o (commit),
    .hold_o   (hold)
  );

  always_comb begin
    wr_idx    = hold.addr[31:2];
    csr_d     = csr_q;
    csr_w_v_d = '0;
    bvalid_d  = bvalid_q & ~bready_i;
    bresp_d   = bresp_q;
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = e_axil_slverr;
      for (int unsigned k = 0; k < num_csr_p; k++) begin
        if (wr_idx == 30'(k)) begin
          bresp_d      = e_axil_okay;
          csr_w_v_d[k] = 1'b1;
          for (int unsigned b = 0; b < 4; b++) begin
            if (hold.strb[b]) csr_d[k][8*b +: 8] = hold.data[8*b +: 8];
          end
        end
      end
    end
  end

  // Reads see csr_q, so a same-cycle commit to the same register is not visible yet.
  always_comb begin
    ar_addr_ext = 32'(araddr_i);
    rd_idx      = ar_addr_ext[31:2];
    arready_o   = (~rvalid_q | rready_i) & ~reset_i;
    rvalid_d    = rvalid_q & ~rready_i;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    if (arvalid_i & arready_o) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = e_axil_slverr;
      for (int unsigned k = 0; k < num_csr_p; k++) begin
        if (rd_idx == 30'(k)) begin
          rdata_d = csr_q[k];
          rresp_d = e_axil_okay;
        end
      end
      for (int unsigned k = 0; k < num_ro_p; k++) begin
        if (rd_idx == 30'(num_csr_p + k)) begin
          rdata_d = ro_data_i[32*k +: 32];
          rresp_d = e_axil_okay;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      csr_q     <= '0;
      csr_w_v_q <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      csr_q     <= csr_d;
      csr_w_v_q <= csr_w_v_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign csr_data_o = csr_q;
  assign csr_w_v_o  = csr_w_v_q;
  assign bvalid_o   = bvalid_q;
  assign bresp_o    = bresp_q;
  assign rvalid_o   = rvalid_q;
  assign rresp_o    = rresp_q;
  assign rdata_o    = rdata_q;

endmodule

// File: tb/tb_zynq_axil_csr_responder.sv
// Directed bench for zynq_axil_csr_responder with B/R response scoreboards.
module tb_zynq_axil_csr_responder;

  localparam int unsigned NCSR = 4;
  localparam int unsigned NRO  = 2;

  logic              clk = 1'b0;
  logic              reset_i;
  logic [9:0]        awaddr_i, araddr_i;
  logic [2:0]        awprot_i, arprot_i;
  logic              awvalid_i, awready_o, wvalid_i, wready_o;
  logic [31:0]       wdata_i, rdata_o;
  logic [3:0]        wstrb_i;
  logic [1:0]        bresp_o, rresp_o;
  logic              bvalid_o, bready_i, arvalid_i, arready_o, rvalid_o, rready_i;
  logic [NCSR*32-1:0] csr_data_o;
  logic [NCSR-1:0]   csr_w_v_o;
  logic [NRO*32-1:0] ro_data_i;

  int checks   = 0;
  int failures = 0;

  logic [1:0]  bq[$];
  logic [33:0] rq[$];
  logic [31:0] model[NCSR];

  always #5 clk = ~clk;

  zynq_axil_csr_responder #(
    .addr_width_p(10),
    .data_width_p(32),
    .num_csr_p   (NCSR),
    .num_ro_p    (NRO)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .awaddr_i  (awaddr_i),
    .awprot_i  (awprot_i),
    .awvalid_i (awvalid_i),
    .awready_o (awready_o),
    .wdata_i   (wdata_i),
    .wstrb_i   (wstrb_i),
    .wvalid_i  (wvalid_i),
    .wready_o  (wready_o),
    .bresp_o   (bresp_o),
    .bvalid_o  (bvalid_o),
    .bready_i  (bready_i),
    .araddr_i  (araddr_i),
    .arprot_i  (arprot_i),
    .arvalid_i (arvalid_i),
    .arready_o (arready_o),
    .rdata_o   (rdata_o),
    .rresp_o   (rresp_o),
    .rvalid_o  (rvalid_o),
    .rready_i  (rready_i),
    .csr_data_o(csr_data_o),
    .csr_w_v_o (csr_w_v_o),
    .ro_data_i (ro_data_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_csrs(input string tag);
    for (int k = 0; k < NCSR; k++)
      chk($sformatf("%s_csr%0d", tag, k), 64'(csr_data_o[32*k +: 32]), 64'(model[k]));
  endtask

  task automatic model_write(input logic [9:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [3:0] pulse);
    int idx;
    idx   = int'(addr[9:2]);
    pulse = '0;
    if (idx < NCSR) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
      pulse[idx] = 1'b1;
      bq.push_back(2'b00);
    end else begin
      bq.push_back(2'b10);
    end
  endtask

  function automatic logic [33:0] rd_expect(input logic [9:0] addr);
    int idx;
    idx = int'(addr[9:2]);
    if (idx < NCSR) return {2'b00, model[idx]};
    if (idx < NCSR + NRO) return {2'b00, ro_data_i[32*(idx-NCSR) +: 32]};
    return {2'b10, 32'h0};
  endfunction

  // Called at a negedge; returns at the negedge after both handshakes completed.
  task automatic wr_send(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit aw_done = 0;
    bit w_done  = 0;
    int n = 0;
    awaddr_i = addr; awvalid_i = 1'b1;
    wdata_i = data; wstrb_i = strb; wvalid_i = 1'b1;
    while (!(aw_done && w_done)) begin
      #1;
      if (awvalid_i && awready_o) aw_done = 1;
      if (wvalid_i && wready_o) w_done = 1;
      @(negedge clk);
      if (aw_done) awvalid_i = 1'b0;
      if (w_done) wvalid_i = 1'b0;
      n++;
      if (n > 20) begin
        chk("wr_handshake_timeout", 64'(n), 64'(0));
        awvalid_i = 1'b0; wvalid_i = 1'b0;
        return;
      end
    end
  endtask

  task automatic wait_b(input logic [3:0] exp_pulse, input int exp_lat);
    int n = 0;
    while (!bvalid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bvalid_o) begin
      chk("b_timeout", 64'(bvalid_o), 64'(1));
      return;
    end
    if (exp_lat >= 0) chk("b_latency", 64'(n), 64'(exp_lat));
    chk("bresp", 64'(bresp_o), 64'(bq.pop_front()));
    chk("w_pulse", 64'(csr_w_v_o), 64'(exp_pulse));
    check_csrs("after_b");
    @(negedge clk);
    chk("pulse_clear", 64'(csr_w_v_o), 64'(0));
    chk("bvalid_clear", 64'(bvalid_o), 64'(0));
  endtask

  task automatic rd_send(input logic [9:0] addr);
    int n = 0;
    araddr_i = addr; arvalid_i = 1'b1;
    rq.push_back(rd_expect(addr));
    #1;
    while (!arready_o && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!arready_o) chk("ar_timeout", 64'(arready_o), 64'(1));
    @(negedge clk);
    arvalid_i = 1'b0;
  endtask

  task automatic wait_r();
    logic [33:0] e;
    int n = 0;
    while (!rvalid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rvalid_o) begin
      chk("r_timeout", 64'(rvalid_o), 64'(1));
      return;
    end
    e = rq.pop_front();
    chk("rdata", 64'(rdata_o), 64'(e[31:0]));
    chk("rresp", 64'(rresp_o), 64'(e[33:32]));
    @(negedge clk);
    chk("rvalid_clear", 64'(rvalid_o), 64'(0));
  endtask

  initial begin
    logic [3:0]  p, p2;
    logic [33:0] e;

    reset_i = 1'b1;
    awaddr_i = '0; awprot_i = '0; awvalid_i = 1'b0;
    wdata_i = '0; wstrb_i = '0; wvalid_i = 1'b0;
    araddr_i = '0; arprot_i = '0; arvalid_i = 1'b0;
    bready_i = 1'b1; rready_i = 1'b1;
    ro_data_i = {32'h0BAD_F00D, 32'hA5A5_0001};
    for (int k = 0; k < NCSR; k++) model[k] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_awready", 64'(awready_o), 64'(0));
    chk("rst_wready", 64'(wready_o), 64'(0));
    chk("rst_arready", 64'(arready_o), 64'(0));
    reset_i = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", 64'(awready_o), 64'(1));
    chk("post_rst_wready", 64'(wready_o), 64'(1));
    chk("post_rst_arready", 64'(arready_o), 64'(1));
    chk("post_rst_bvalid", 64'(bvalid_o), 64'(0));
    chk("post_rst_rvalid", 64'(rvalid_o), 64'(0));
    chk("post_rst_rdata", 64'(rdata_o), 64'(0));
    chk("post_rst_pulse", 64'(csr_w_v_o), 64'(0));
    check_csrs("post_rst");

    // AW and W together to reg1
    model_write(10'h004, 32'hDEAD_BEEF, 4'hF, p);
    wr_send(10'h004, 32'hDEAD_BEEF, 4'hF);
    wait_b(p, 1);

    // reg0 all ones, then W-before-AW partial-strobe write
    model_write(10'h000, 32'hFFFF_FFFF, 4'hF, p);
    wr_send(10'h000, 32'hFFFF_FFFF, 4'hF);
    wait_b(p, 1);
    wdata_i = 32'h1234_5678; wstrb_i = 4'b0101; wvalid_i = 1'b1;
    #1 chk("wfirst_wready", 64'(wready_o), 64'(1));
    @(negedge clk);
    wvalid_i = 1'b0;
    chk("wfirst_wready_low", 64'(wready_o), 64'(0));
    chk("wfirst_awready", 64'(awready_o), 64'(1));
    repeat (2) begin
      @(negedge clk);
      chk("wfirst_no_b", 64'(bvalid_o), 64'(0));
    end
    awaddr_i = 10'h000; awvalid_i = 1'b1;
    #1 chk("wfirst_aw_ready", 64'(awready_o), 64'(1));
    @(negedge clk);
    awvalid_i = 1'b0;
    model_write(10'h000, 32'h1234_5678, 4'b0101, p);
    wait_b(p, 1);
    chk("partial_reg0", 64'(csr_data_o[31:0]), 64'(32'hFF34_FF78));

    // RO and out-of-range writes; out-of-range read
    model_write(10'h010, 32'h5555_5555, 4'hF, p);
    wr_send(10'h010, 32'h5555_5555, 4'hF);
    wait_b(p, 1);
    model_write(10'h018, 32'h6666_6666, 4'hF, p);
    wr_send(10'h018, 32'h6666_6666, 4'hF);
    wait_b(p, 1);
    rd_send(10'h018); wait_r();
    rd_send(10'h004); wait_r();
    rd_send(10'h014); wait_r();

    // RO read held by rready=0
    rready_i = 1'b0;
    rd_send(10'h010);
    e = rq.pop_front();
    repeat (5) begin
      chk("rstall_rvalid", 64'(rvalid_o), 64'(1));
      chk("rstall_rdata", 64'(rdata_o), 64'(e[31:0]));
      chk("rstall_arready", 64'(arready_o), 64'(0));
      @(negedge clk);
    end
    rready_i = 1'b1;
    chk("rstall_rresp", 64'(rresp_o), 64'(e[33:32]));
    @(negedge clk);
    chk("rstall_clear", 64'(rvalid_o), 64'(0));

    // Back-to-back reads
    araddr_i = 10'h000; arvalid_i = 1'b1;
    rq.push_back(rd_expect(10'h000));
    @(negedge clk);
    araddr_i = 10'h004;
    rq.push_back(rd_expect(10'h004));
    chk("b2b_arready", 64'(arready_o), 64'(1));
    e = rq.pop_front();
    chk("b2b_rdata0", 64'(rdata_o), 64'(e[31:0]));
    @(negedge clk);
    arvalid_i = 1'b0;
    e = rq.pop_front();
    chk("b2b_rvalid1", 64'(rvalid_o), 64'(1));
    chk("b2b_rdata1", 64'(rdata_o), 64'(e[31:0]));
    @(negedge clk);
    chk("b2b_clear", 64'(rvalid_o), 64'(0));

    // B stall with a second write held
    bready_i = 1'b0;
    model_write(10'h008, 32'h1111_1111, 4'hF, p);
    wr_send(10'h008, 32'h1111_1111, 4'hF);
    @(negedge clk);
    chk("bstall_bvalid", 64'(bvalid_o), 64'(1));
    chk("bstall_pulse1", 64'(csr_w_v_o), 64'(p));
    awaddr_i = 10'h00C; awvalid_i = 1'b1;
    wdata_i = 32'h2222_2222; wstrb_i = 4'hF; wvalid_i = 1'b1;
    #1 chk("bstall_readies", 64'({awready_o, wready_o}), 64'(2'b11));
    @(negedge clk);
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    repeat (3) begin
      chk("bstall_awready", 64'(awready_o), 64'(0));
      chk("bstall_wready", 64'(wready_o), 64'(0));
      chk("bstall_hold_b", 64'({bvalid_o, bresp_o}), 64'({1'b1, bq[0]}));
      chk("bstall_no_pulse", 64'(csr_w_v_o), 64'(0));
      chk("bstall_reg3", 64'(csr_data_o[127:96]), 64'(model[3]));
      @(negedge clk);
    end
    bready_i = 1'b1;
    chk("bstall_first_bresp", 64'(bresp_o), 64'(bq.pop_front()));
    model_write(10'h00C, 32'h2222_2222, 4'hF, p2);
    @(negedge clk);
    chk("bstall_second_bvalid", 64'(bvalid_o), 64'(1));
    chk("bstall_second_bresp", 64'(bresp_o), 64'(bq.pop_front()));
    chk("bstall_second_pulse", 64'(csr_w_v_o), 64'(p2));
    check_csrs("bstall");
    @(negedge clk);
    chk("bstall_done", 64'(bvalid_o), 64'(0));

    // Reset with B pending and read outstanding
    bready_i = 1'b0; rready_i = 1'b0;
    model_write(10'h000, 32'hCAFE_F00D, 4'hF, p);
    wr_send(10'h000, 32'hCAFE_F00D, 4'hF);
    rd_send(10'h004);
    chk("prerst_pending", 64'({bvalid_o, rvalid_o}), 64'(2'b11));
    reset_i = 1'b1;
    #1 chk("midrst_readies", 64'({awready_o, wready_o, arready_o}), 64'(0));
    @(negedge clk);
    bq.delete(); rq.delete();
    for (int k = 0; k < NCSR; k++) model[k] = '0;
    chk("midrst_bvalid", 64'(bvalid_o), 64'(0));
    chk("midrst_rvalid", 64'(rvalid_o), 64'(0));
    chk("midrst_resp_data", 64'({bresp_o, rresp_o, rdata_o}), 64'(0));
    check_csrs("midrst");
    reset_i = 1'b0; bready_i = 1'b1; rready_i = 1'b1;
    @(negedge clk);
    chk("after_midrst_readies", 64'({awready_o, wready_o, arready_o}), 64'(3'b111));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
